jk_cmd_bank: RTL and testbench

- Command-driven front end for a bank of JK storage bits.
- Accepts set/clear/toggle/hold commands with a bit mask over a valid/ready handshake and buffers them in a small FIFO.
- Drives per-bit J/K vectors for a programmable number of cycles and holds the resulting JK register state.
- Sits directly upstream of the JK flip-flop bank it controls. Q/QN are the bank outputs consumed downstream.

---
 rtl/jk_pkg.sv | 29 ++
 rtl/jk_cmd_fifo.sv | 65 ++++++
 rtl/jk_cmd_bank.sv | 172 +++++++++++++++++
 tb/tb_jk_cmd_bank.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// -----------------------------------------------------------------------------
// jk_pkg
//   Shared types for the JK command bank.
//   - jk_op_t     : 2-bit command opcode, bit order {J,K}
//   - jk_state_e  : executor FSM states
//   - jk_next()   : next state of one JK storage bit
// -----------------------------------------------------------------------------
package jk_pkg;

  typedef logic [1:0] jk_op_t;

  localparam jk_op_t OP_HOLD = 2'b00;
  localparam jk_op_t OP_CLR  = 2'b01;
  localparam jk_op_t OP_SET  = 2'b10;
  localparam jk_op_t OP_TGL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } jk_state_e;

  // Characteristic equation of a JK flip-flop: Q+ = J&~Q | ~K&Q
  // (00 hold, 01 clear, 10 set, 11 invert).
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    return (j & ~q) | (~k & q);
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// -----------------------------------------------------------------------------
// jk_cmd_fifo
//   Circular command buffer. Pointers carry one wrap bit above the index so
//   full and empty come straight from the pointers, no separate counter.
//   A pushed entry becomes visible at head only after the push edge (no
//   bypass), so an empty FIFO never pops.
// Ports
//   CP    in   clock, rising edge
//   CD    in   synchronous active-high reset (empties the buffer)
//   push  in   write wdata at this edge (ignored when full)
//   pop   in   advance read pointer at this edge (ignored when empty)
//   wdata in   entry to write
//   head  out  oldest entry (valid when !empty)
//   full  out  DEPTH entries stored
//   empty out  no entries stored
// -----------------------------------------------------------------------------
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 14
) (
  input  logic          CP,
  input  logic          CD,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Same index with opposite wrap bits means the writer lapped the reader.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign head = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CP) begin
    if (CD) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: contents are only observed between the pointers.
  always_ff @(posedge CP) begin
    if (!CD && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/jk_cmd_bank.sv
// -----------------------------------------------------------------------------
// jk_cmd_bank
//   Command-driven front end for a bank of WIDTH JK storage bits. Commands
//   (op, mask, repeat) are queued in a small FIFO; an executor applies each
//   command's J/K vectors for rpt+1 cycles, and the JK register Q follows the
//   J/K vectors one edge later.
//
// Handshake: a command is accepted on a CP edge where cmd_valid && cmd_ready.
//   cmd_ready = !full, derived from the FIFO pointers only and independent of
//   cmd_valid. cmd_op/cmd_mask/cmd_rpt are don't-care while cmd_valid is low.
//
// Ports
//   CP         in   clock, rising edge
//   CD         in   synchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  FIFO can accept (= !full)
//   cmd_op     in   00 hold, 01 clear, 10 set, 11 toggle ({J,K})
//   cmd_mask   in   bits affected; unmasked bits see J=K=0
//   cmd_rpt    in   extra applications (total rpt+1)
//   J, K       out  registered J/K vectors applied this cycle
//   Q          out  bank state
//   QN         out  ~Q
//   busy       out  executor not IDLE or FIFO non-empty
//   done       out  one-cycle pulse after the last application of a command
//   dbg_state  out  executor FSM state
// -----------------------------------------------------------------------------
module jk_cmd_bank
  import jk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             CP,
  input  logic             CD,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  jk_op_t           cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_rpt,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             busy,
  output logic             done,
  output jk_state_e        dbg_state
);

  localparam int EW = 2 + WIDTH + CNT_W;

  jk_state_e        state;
  jk_op_t           act_op;
  logic [WIDTH-1:0] act_mask;
  logic [CNT_W-1:0] rpt_cnt;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [EW-1:0]    fifo_wdata;
  logic [EW-1:0]    fifo_head;

  jk_op_t           head_op;
  logic [WIDTH-1:0] head_mask;
  logic [CNT_W-1:0] head_rpt;

  logic [WIDTH-1:0] q_next;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  assign cmd_ready  = !fifo_full;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_wdata = {cmd_op, cmd_mask, cmd_rpt};

  // The executor takes a new command whenever it is between commands.
  assign fifo_pop = ((state == S_IDLE) || (state == S_DONE)) && !fifo_empty;

  assign head_op   = fifo_head[EW-1 -: 2];
  assign head_mask = fifo_head[CNT_W +: WIDTH];
  assign head_rpt  = fifo_head[CNT_W-1:0];

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .DW    (EW)
  ) u_fifo (
    .CP    (CP),
    .CD    (CD),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // JK bank next state from the J/K vectors present this cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    q_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      q_next[i] = jk_next(Q[i], J[i], K[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Executor FSM, repeat counter and bank register.
  // J/K/done are registered from the state in effect at the edge, so they
  // trail dbg_state by one cycle: a command popped at edge p drives J/K in
  // cycles p+1 .. p+1+rpt and pulses done in cycle p+rpt+2. The repeat counter
  // only decrements, so rpt = all-ones simply runs 2^CNT_W applications.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CP) begin
    if (CD) begin
      state    <= S_IDLE;
      act_op   <= OP_HOLD;
      act_mask <= '0;
      rpt_cnt  <= '0;
      J        <= '0;
      K        <= '0;
      done     <= 1'b0;
      Q        <= '0;
    end else begin
      Q    <= q_next;
      done <= (state == S_DONE);

      if (state == S_APPLY) begin
        J <= act_mask & {WIDTH{act_op[1]}};
        K <= act_mask & {WIDTH{act_op[0]}};
      end else begin
        J <= '0;
        K <= '0;
      end

      case (state)
        S_IDLE: begin
          if (fifo_pop) begin
            act_op   <= head_op;
            act_mask <= head_mask;
            rpt_cnt  <= head_rpt;
            state    <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (rpt_cnt == '0) begin
            state <= S_DONE;
          end else begin
            rpt_cnt <= rpt_cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (fifo_pop) begin
            act_op   <= head_op;
            act_mask <= head_mask;
            rpt_cnt  <= head_rpt;
            state    <= S_APPLY;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign QN        = ~Q;
  assign busy      = (state != S_IDLE) || !fifo_empty;
  assign dbg_state = state;

endmodule

// File: tb/tb_jk_cmd_bank.sv
// -----------------------------------------------------------------------------
// tb_jk_cmd_bank
//   Directed bench for jk_cmd_bank. Inputs change 1 time unit after each
//   rising edge and outputs are sampled at the same point, so "cycle n" is the
//   interval following edge n, counted from the edge that accepts a command.
// -----------------------------------------------------------------------------
module tb_jk_cmd_bank;
  import jk_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             CP = 1'b0;
  logic             CD;
  logic             cmd_valid;
  logic             cmd_ready;
  jk_op_t           cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_rpt;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] QN;
  logic             busy;
  logic             done;
  jk_state_e        dbg_state;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expected done-pulse cycle numbers for the back-to-back run.
  logic [7:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  always #5 CP = ~CP;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  jk_cmd_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .CP        (CP),
    .CD        (CD),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_rpt   (cmd_rpt),
    .J         (J),
    .K         (K),
    .Q         (Q),
    .QN        (QN),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic drive(input jk_op_t op, input logic [WIDTH-1:0] mask,
                       input logic [CNT_W-1:0] rpt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_rpt   = rpt;
  endtask

  // Payload is don't-care while cmd_valid is low, so scramble it.
  task automatic idle_in();
    cmd_valid = 1'b0;
    cmd_op    = jk_op_t'($urandom_range(0, 3));
    cmd_mask  = WIDTH'($urandom_range(0, 255));
    cmd_rpt   = CNT_W'($urandom_range(0, 15));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    jk_op_t           b_op   [5];
    logic [WIDTH-1:0] b_mask [5];
    logic [CNT_W-1:0] b_rpt  [5];
    int               n_done;
    int               n_j;

    // ---- Reset with cmd_valid high: nothing may be pushed ----
    CD = 1'b1;
    drive(OP_SET, 8'hFF, 4'd0);
    tick();
    tick();
    chk("rst_q",     32'(Q), 32'h00);
    chk("rst_qn",    32'(QN), 32'hFF);
    chk("rst_j",     32'(J), 32'h00);
    chk("rst_k",     32'(K), 32'h00);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    CD = 1'b0;
    idle_in();
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_q",    32'(Q), 32'h00);
    end

    // ---- Single set: op=10 mask=A5 rpt=0 ----
    drive(OP_SET, 8'hA5, 4'd0);
    tick();
    idle_in();
    tick();                                   // cycle t+1
    chk("set_j_t1",    32'(J), 32'h00);
    chk("set_busy_t1", 32'(busy), 32'd1);
    tick();                                   // cycle t+2
    chk("set_j_t2",    32'(J), 32'hA5);
    chk("set_k_t2",    32'(K), 32'h00);
    chk("set_q_t2",    32'(Q), 32'h00);
    chk("set_done_t2", 32'(done), 32'd0);
    tick();                                   // cycle t+3
    chk("set_q_t3",    32'(Q), 32'hA5);
    chk("set_qn_t3",   32'(QN), 32'h5A);
    chk("set_done_t3", 32'(done), 32'd1);
    chk("set_j_t3",    32'(J), 32'h00);
    tick();                                   // cycle t+4
    chk("set_done_t4", 32'(done), 32'd0);
    chk("set_q_t4",    32'(Q), 32'hA5);
    chk("set_busy_t4", 32'(busy), 32'd0);

    // ---- Toggle with repeat: op=11 mask=0F rpt=2 from Q=A5 ----
    drive(OP_TGL, 8'h0F, 4'd2);
    tick();
    idle_in();
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk("tgl_j",    32'(J), (c >= 2 && c <= 4) ? 32'h0F : 32'h00);
      chk("tgl_k",    32'(K), (c >= 2 && c <= 4) ? 32'h0F : 32'h00);
      chk("tgl_done", 32'(done), (c == 5) ? 32'd1 : 32'd0);
      chk("tgl_q",    32'(Q), (c <= 2) ? 32'hA5 : (c == 3) ? 32'hAA :
                              (c == 4) ? 32'hA5 : 32'hAA);
    end

    // ---- Five back-to-back commands into a 4-deep FIFO ----
    // First command runs 6 applications, so the FIFO fills after the 5th push
    // (pop of the 1st at edge 2) and drains again at edge 9.
    b_op   = '{OP_SET, OP_CLR, OP_TGL, OP_HOLD, OP_SET};
    b_mask = '{8'hFF, 8'h0F, 8'h3C, 8'hFF, 8'h01};
    b_rpt  = '{4'd5, 4'd0, 4'd0, 4'd1, 4'd2};
    exp_q  = '{8'd9, 8'd11, 8'd13, 8'd16, 8'd20};
    for (int c = 1; c <= 24; c++) begin
      if (c <= 5) drive(b_op[c-1], b_mask[c-1], b_rpt[c-1]);
      else        idle_in();
      tick();
      chk("b2b_ready", 32'(cmd_ready), (c >= 5 && c <= 8) ? 32'd0 : 32'd1);
      if (done) begin
        if (exp_q.size() == 0) chk("b2b_extra_done", 32'(done), 32'd0);
        else                   chk("b2b_done_cycle", 32'(c), 32'(exp_q.pop_front()));
      end
    end
    idle_in();
    chk("b2b_done_count_left", 32'(exp_q.size()), 32'd0);
    chk("b2b_final_q",         32'(Q), 32'hCD);
    chk("b2b_idle_busy",       32'(busy), 32'd0);

    // ---- Clear then hold: Q=FF, clr 3C, hold FF rpt=3 ----
    drive(OP_SET, 8'hFF, 4'd0);
    tick();
    idle_in();
    repeat (4) tick();
    chk("mix_pre_q", 32'(Q), 32'hFF);
    drive(OP_CLR, 8'h3C, 4'd0);
    tick();                                   // c=1
    drive(OP_HOLD, 8'hFF, 4'd3);
    tick();                                   // c=2
    idle_in();
    n_done = 0;
    for (int c = 3; c <= 12; c++) begin
      tick();
      if (done) n_done++;
      chk("mix_q",    32'(Q), (c >= 4) ? 32'hC3 : 32'hFF);
      chk("mix_j",    32'(J), 32'h00);
      chk("mix_k",    32'(K), (c == 3) ? 32'h3C : 32'h00);
      chk("mix_done", 32'(done), (c == 4 || c == 9) ? 32'd1 : 32'd0);
    end
    chk("mix_done_count", 32'(n_done), 32'd2);

    // ---- rpt all-ones: 16 toggles of mask 81 leave Q unchanged ----
    drive(OP_TGL, 8'h81, 4'hF);
    tick();                                   // c=1
    idle_in();
    n_j = 0;
    for (int c = 2; c <= 21; c++) begin
      tick();
      if (J === 8'h81 && K === 8'h81) n_j++;
      chk("rmax_done", 32'(done), (c == 19) ? 32'd1 : 32'd0);
      if (c == 4) chk("rmax_q_first", 32'(Q), 32'h42);
    end
    chk("rmax_apps",  32'(n_j), 32'd16);
    chk("rmax_q_end", 32'(Q), 32'hC3);

    // ---- mask=0: full duration, done pulse, no effect ----
    drive(OP_SET, 8'h00, 4'd1);
    tick();                                   // c=1
    idle_in();
    for (int c = 2; c <= 7; c++) begin
      tick();
      chk("m0_j",    32'(J), 32'h00);
      chk("m0_done", 32'(done), (c == 5) ? 32'd1 : 32'd0);
      chk("m0_busy", 32'(busy), (c <= 4) ? 32'd1 : 32'd0);
      chk("m0_q",    32'(Q), 32'hC3);
    end

    // ---- Reset during APPLY of rpt=7 toggle with 2 queued commands ----
    drive(OP_TGL, 8'hFF, 4'd7);
    tick();                                   // c=1
    drive(OP_SET, 8'hFF, 4'd0);
    tick();                                   // c=2
    drive(OP_CLR, 8'hFF, 4'd0);
    tick();                                   // c=3
    idle_in();
    tick();                                   // c=4
    chk("mid_busy_pre", 32'(busy), 32'd1);
    chk("mid_j_pre",    32'(J), 32'hFF);
    chk("mid_q_pre",    32'(Q), 32'h3C);
    CD = 1'b1;
    tick();                                   // c=5, reset edge
    CD = 1'b0;
    chk("mid_rst_q",     32'(Q), 32'h00);
    chk("mid_rst_j",     32'(J), 32'h00);
    chk("mid_rst_k",     32'(K), 32'h00);
    chk("mid_rst_busy",  32'(busy), 32'd0);
    chk("mid_rst_done",  32'(done), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
    for (int c = 6; c <= 17; c++) begin
      tick();
      chk("mid_after_done", 32'(done), 32'd0);
      chk("mid_after_j",    32'(J), 32'h00);
      chk("mid_after_q",    32'(Q), 32'h00);
      chk("mid_after_busy", 32'(busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
